// File: rtl/auction_pkg.sv
// auction_pkg: shared constants, FSM state type and bid array type for the auction pipeline
package auction_pkg;
    localparam int NUM_BIDDERS = 10;
    localparam int ID_W = 4;
    localparam int BID_W = 17;
    typedef enum logic [1:0] {COLLECT, PRESENT, CLEAR} collector_state_e;
    typedef logic [NUM_BIDDERS-1:0][BID_W-1:0] bid_array_t;
    function automatic logic all_present(input logic [NUM_BIDDERS-1:0] mask);
        return &mask;
    endfunction
endpackage

// File: rtl/auction_bid_collector_if.sv
// auction_bid_collector_if: valid/ready bid stream, one bidder id and value per beat
interface auction_bid_collector_if #(parameter int bW = 17) ();
    import auction_pkg::*;
    logic bid_valid;
    logic bid_ready;
    logic [ID_W-1:0] bid_id;
    logic [bW-1:0] bid_value;
    modport master (output bid_valid, bid_id, bid_value, input bid_ready);
    modport slave (input bid_valid, bid_id, bid_value, output bid_ready);
endinterface

// File: rtl/auction_round_timer.sv
// auction_round_timer: counts cycles since the first stored bid and flags expiry; 0 disables
module auction_round_timer #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            clear,
    input  logic [TO_W-1:0] timeout_cycles,
    output logic            expire
);
    logic [TO_W-1:0] count_q, count_d;
    assign expire = run && (timeout_cycles != '0) && (count_q == timeout_cycles - TO_W'(1));
    // next count: cleared between rounds, advancing while the round holds bids
    always_comb count_d = clear ? '0 : run ? count_q + TO_W'(1) : count_q;
    // counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else     count_q <= count_d;
endmodule

// File: rtl/auction_bid_collector.sv
// auction_bid_collector: gathers one round of bids and presents the frozen array to argmax
module auction_bid_collector
    import auction_pkg::*;
#(
    parameter int bW   = 17,
    parameter int TO_W = 8,
    parameter int HOLD = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    auction_bid_collector_if.slave          bus,
    input  logic                            close_req,
    input  logic [TO_W-1:0]                 timeout_cycles,
    output logic [NUM_BIDDERS-1:0][bW-1:0]  bids,
    output logic [NUM_BIDDERS-1:0]          present_mask,
    output logic                            bids_valid,
    output logic [7:0]                      round_id,
    output logic                            err_dup,
    output logic                            err_id
);
    localparam int HW = $clog2(HOLD + 1);
    collector_state_e state_q;
    logic [NUM_BIDDERS-1:0][bW-1:0] bids_q, bids_d;
    logic [NUM_BIDDERS-1:0] mask_q, mask_d, onehot;
    logic [HW-1:0] hold_q;
    logic [7:0] round_q;
    logic valid_q, err_dup_q, err_id_q;
    logic accept, legal, dup, store, run, expire, close;
    assign bus.bid_ready = (state_q == COLLECT);
    assign accept = bus.bid_valid && bus.bid_ready;
    assign legal = bus.bid_id < ID_W'(NUM_BIDDERS);
    assign onehot = legal ? NUM_BIDDERS'(1) << bus.bid_id : '0;
    assign dup = |(mask_q & onehot);
    assign store = accept && legal && !dup;
    assign run = (state_q == COLLECT) && (mask_d != '0);
    assign close = (state_q == COLLECT) && (all_present(mask_d) || expire || (close_req && mask_d != '0));
    // array and mask as they stand after this cycle's write; first value per bidder wins
    always_comb begin
        mask_d = store ? mask_q | onehot : mask_q;
        bids_d = bids_q;
        for (int i = 0; i < NUM_BIDDERS; i++) bids_d[i] = (store && onehot[i]) ? bus.bid_value : bids_q[i];
    end
    auction_round_timer #(.TO_W(TO_W)) u_timer (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .clear          (state_q == CLEAR),
        .timeout_cycles (timeout_cycles),
        .expire         (expire)
    );
    // round FSM: collect, hold the frozen array for HOLD cycles, then clear and advance round
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            bids_q    <= '0;
            mask_q    <= '0;
            hold_q    <= '0;
            round_q   <= '0;
            valid_q   <= 1'b0;
            err_dup_q <= 1'b0;
            err_id_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            err_dup_q <= 1'b0;
            err_id_q  <= 1'b0;
            unique case (state_q)
                COLLECT: begin
                    bids_q    <= bids_d;
                    mask_q    <= mask_d;
                    err_dup_q <= accept && dup;
                    err_id_q  <= accept && !legal;
                    if (close) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                PRESENT: begin
                    hold_q <= hold_q + HW'(1);
                    if (hold_q == HW'(HOLD - 1)) state_q <= CLEAR;
                end
                CLEAR: begin
                    bids_q  <= '0;
                    mask_q  <= '0;
                    round_q <= round_q + 8'd1;
                    state_q <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
    assign bids = bids_q;
    assign present_mask = mask_q;
    assign bids_valid = valid_q;
    assign round_id = round_q;
    assign err_dup = err_dup_q;
    assign err_id = err_id_q;
endmodule

// File: tb/tb_auction_bid_collector.sv
// tb_auction_bid_collector: directed rounds checked against a cycle-offset model of the collector
module tb_auction_bid_collector;
    import auction_pkg::*;
    localparam int BW = 17;
    localparam int TOW = 8;
    localparam int HOLD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic close_req = 1'b0;
    logic [TOW-1:0] tc = '0;
    logic [9:0][BW-1:0] bids;
    logic [9:0] present_mask;
    logic bids_valid, err_dup, err_id;
    logic [7:0] round_id;
    int n_vec = 0;
    int n_err = 0;
    auction_bid_collector_if #(.bW(BW)) bus ();
    auction_bid_collector #(.bW(BW), .TO_W(TOW), .HOLD(HOLD)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .close_req      (close_req),
        .timeout_cycles (tc),
        .bids           (bids),
        .present_mask   (present_mask),
        .bids_valid     (bids_valid),
        .round_id       (round_id),
        .err_dup        (err_dup),
        .err_id         (err_id)
    );
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: since = cycles after the closing edge (-1 while collecting)
    logic [BW-1:0] m_bids [10];
    logic [9:0] m_mask;
    logic [7:0] m_round;
    logic m_valid, m_edup, m_eid;
    int m_since, m_first, m_cyc;
    logic [169:0] m_packed;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) m_bids[i] = '0;
            m_mask = '0; m_round = '0; m_valid = 0; m_edup = 0; m_eid = 0;
            m_since = -1; m_first = -1; m_cyc = 0;
        end else begin
            m_cyc++;
            m_valid = 0; m_edup = 0; m_eid = 0;
            if (m_since < 0) begin
                if (bus.bid_valid) begin
                    if (bus.bid_id >= 4'd10) m_eid = 1;
                    else if (m_mask[bus.bid_id]) m_edup = 1;
                    else begin
                        m_mask[bus.bid_id] = 1'b1;
                        m_bids[bus.bid_id] = bus.bid_value;
                        if (m_first < 0) m_first = m_cyc;
                    end
                end
                if (m_mask == 10'h3FF || (close_req && m_mask != 0) ||
                    (tc != 0 && m_first >= 0 && ((m_cyc - m_first) % 256) == int'(tc) - 1)) begin
                    m_since = 1;
                    m_valid = 1;
                end
            end else if (m_since == HOLD + 1) begin
                for (int i = 0; i < 10; i++) m_bids[i] = '0;
                m_mask = '0;
                m_round = m_round + 8'd1;
                m_since = -1;
                m_first = -1;
            end else m_since++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 10; i++) m_packed[i*BW +: BW] = m_bids[i];
            chk("ready", bus.bid_ready, m_since < 0);
            chk("bids_valid", bids_valid, m_valid);
            chk("mask", present_mask, m_mask);
            chk("round_id", round_id, m_round);
            chk("err_dup", err_dup, m_edup);
            chk("err_id", err_id, m_eid);
            chk("bids", bids, m_packed);
        end
    end

    task automatic send(input logic [3:0] id, input logic [BW-1:0] v, input bit cr, output int waits);
        waits = 0;
        bus.bid_valid = 1; bus.bid_id = id; bus.bid_value = v; close_req = cr;
        while (!bus.bid_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("send_ready", bus.bid_ready, 1);
        @(negedge clk);
        bus.bid_valid = 0; close_req = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.bid_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", bus.bid_ready, 1);
    endtask

    task automatic full_round();
        int w = 0;
        int wt;
        for (int i = 0; i < 10; i++) begin
            send(4'(i), BW'(10 * (i + 1)), 0, wt);
            w += wt;
        end
        chk("s1_waits", w, 0);
        chk("s1_valid", bids_valid, 1);
        chk("s1_bid9", bids[9], 100);
        chk("s1_mask", present_mask, 10'h3FF);
        @(negedge clk);
        chk("s1_valid_drop", bids_valid, 0);
        chk("s1_ready_n2", bus.bid_ready, 0);
        @(negedge clk);
        chk("s1_ready_n3", bus.bid_ready, 0);
        @(negedge clk);
        chk("s1_ready_n4", bus.bid_ready, 1);
        chk("s1_round", round_id, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wt;
        bus.bid_valid = 0; bus.bid_id = '0; bus.bid_value = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", bus.bid_ready, 1);
        chk("rst_round", round_id, 0);
        chk("rst_mask", present_mask, 0);
        chk("rst_valid", bids_valid, 0);
        chk("rst_bids", bids, 0);
        full_round();
        tc = 8'd5;
        send(4'd3, 17'd7, 0, wt);
        @(negedge clk);
        send(4'd6, 17'd9, 0, wt);
        @(negedge clk);
        chk("s2_valid_t4", bids_valid, 0);
        @(negedge clk);
        chk("s2_valid_t5", bids_valid, 1);
        chk("s2_mask", present_mask, 10'h048);
        chk("s2_bid0", bids[0], 0);
        chk("s2_bid3", bids[3], 7);
        wait_ready();
        tc = '0;
        send(4'd2, 17'd50, 0, wt);
        chk("s3_nodup", err_dup, 0);
        send(4'd2, 17'd80, 0, wt);
        chk("s3_dup", err_dup, 1);
        send(4'd12, 17'd99, 0, wt);
        chk("s3_id", err_id, 1);
        chk("s3_dup_once", err_dup, 0);
        close_req = 1;
        @(negedge clk);
        close_req = 0;
        chk("s3_valid", bids_valid, 1);
        chk("s3_mask", present_mask, 10'h004);
        chk("s3_bid2", bids[2], 50);
        wait_ready();
        chk("s3_round", round_id, 3);
        close_req = 1;
        repeat (20) @(negedge clk);
        chk("s4_round", round_id, 3);
        chk("s4_valid", bids_valid, 0);
        send(4'd0, 17'd1, 1, wt);
        chk("s4_close_valid", bids_valid, 1);
        chk("s4_mask", present_mask, 10'h001);
        wait_ready();
        chk("s4_round_after", round_id, 4);
        send(4'd5, 17'd55, 1, wt);
        chk("s5_valid", bids_valid, 1);
        #2 rst = 1;
        #1;
        chk("s5_valid_drop", bids_valid, 0);
        chk("s5_mask", present_mask, 0);
        chk("s5_round", round_id, 0);
        chk("s5_ready", bus.bid_ready, 1);
        chk("s5_bids", bids, 0);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        full_round();
        send(4'd1, 17'd11, 1, wt);
        bus.bid_valid = 1; bus.bid_id = 4'd4; bus.bid_value = 17'd33;
        wt = 0;
        while (!bus.bid_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk("s6_waits", wt, 3);
        chk("s6_round", round_id, 2);
        @(negedge clk);
        bus.bid_valid = 0;
        chk("s6_mask", present_mask, 10'h010);
        chk("s6_bid4", bids[4], 33);
        close_req = 1;
        @(negedge clk);
        close_req = 0;
        wait_ready();
        chk("s6_round_after", round_id, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
